// File: rtl/rdl_subreg_cnt.sv
// Counter field register: incr/decr by a step, wrap or saturate, with overflow/underflow flags.
// Optional macro RDL_SUBREG_CNT_RCLR_EN adds a read strobe 're' that clears the field on read.
module rdl_subreg_cnt #(
    parameter int unsigned   DW         = 32,
    parameter int unsigned   IW         = 8,
    parameter logic [DW-1:0] ResetValue = '0,
    parameter bit            Saturate   = 1'b0,
    parameter logic [DW-1:0] Threshold  = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wd,
    input  logic          de,
    input  logic [DW-1:0] d,
    input  logic          incr,
    input  logic [IW-1:0] incr_val,
    input  logic          decr,
    input  logic [IW-1:0] decr_val,
    input  logic          ovf_clr,
`ifdef RDL_SUBREG_CNT_RCLR_EN
    input  logic          re,
`endif
    output logic [DW-1:0] q,
    output logic          qe,
    output logic [DW-1:0] qs,
    output logic          overflow,
    output logic          underflow,
    output logic          ovf_sticky,
    output logic          thresh
);

    // Two spare bits: bit DW catches the carry, the top bit is the sign of a borrow.
    localparam int unsigned SW = DW + 2;

    logic [DW-1:0] q_r;
    logic [DW-1:0] base;
    logic [DW-1:0] cnt_val;
    logic [SW-1:0] inc_ext;
    logic [SW-1:0] dec_ext;
    logic [SW-1:0] sum;
    logic          rd_clr;
    logic          count_sel;
    logic          ovf_ev;
    logic          unf_ev;

`ifdef RDL_SUBREG_CNT_RCLR_EN
    assign rd_clr = re;
`else
    assign rd_clr = 1'b0;
`endif

    // A clearing read restarts from zero but still applies this cycle's events.
    assign base    = rd_clr ? '0 : q_r;
    assign inc_ext = incr ? SW'(incr_val) : '0;
    assign dec_ext = decr ? SW'(decr_val) : '0;
    assign sum     = SW'(base) + inc_ext - dec_ext;

    assign unf_ev    = sum[SW-1];
    assign ovf_ev    = ~sum[SW-1] & sum[DW];
    assign count_sel = ~we & ~de;

    always_comb begin
        cnt_val = sum[DW-1:0];
        if (Saturate && ovf_ev) begin
            cnt_val = '1;
        end else if (Saturate && unf_ev) begin
            cnt_val = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r        <= ResetValue;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (we) begin
                q_r <= wd;
            end else if (de) begin
                q_r <= d;
            end else begin
                q_r <= cnt_val;
            end
            overflow   <= count_sel & ovf_ev;
            underflow  <= count_sel & unf_ev;
            // Set has priority over a simultaneous clear.
            ovf_sticky <= (count_sel & ovf_ev) | (ovf_sticky & ~ovf_clr);
        end
    end

    assign q      = q_r;
    assign qs     = q_r;
    assign qe     = we | de | rd_clr;
    assign thresh = (q_r >= Threshold);

endmodule

// File: tb/tb_rdl_subreg_cnt.sv
// Bench for rdl_subreg_cnt: a wrapping and a saturating 8-bit instance share stimulus,
// a driver pushes model expectations per cycle and a monitor pops and compares them.
module tb_rdl_subreg_cnt;

    localparam int EW = 21;  // {qs_pre[8], qe, q[8], ovf, unf, sticky, thresh}

    logic       clk;
    logic       rst;
    logic       we;
    logic [7:0] wd;
    logic       de;
    logic [7:0] d;
    logic       incr;
    logic [7:0] incr_val;
    logic       decr;
    logic [7:0] decr_val;
    logic       ovf_clr;
    logic       re;

    logic [7:0] q_a [2];
    logic [7:0] qs_a [2];
    logic       qe_a [2];
    logic       ovf_a [2];
    logic       unf_a [2];
    logic       st_a [2];
    logic       th_a [2];

    logic [EW-1:0] exp_q [$];

    int n_checks;
    int n_fail;

    logic [7:0] m_q [2];
    logic       m_st [2];
    bit         m_sat [2];

    rdl_subreg_cnt #(.DW(8), .IW(8), .ResetValue(8'h10), .Saturate(1'b0), .Threshold(8'h40)) u_wrap (
        .clk(clk), .rst(rst), .we(we), .wd(wd), .de(de), .d(d),
        .incr(incr), .incr_val(incr_val), .decr(decr), .decr_val(decr_val), .ovf_clr(ovf_clr),
`ifdef RDL_SUBREG_CNT_RCLR_EN
        .re(re),
`endif
        .q(q_a[0]), .qe(qe_a[0]), .qs(qs_a[0]), .overflow(ovf_a[0]), .underflow(unf_a[0]),
        .ovf_sticky(st_a[0]), .thresh(th_a[0])
    );

    rdl_subreg_cnt #(.DW(8), .IW(8), .ResetValue(8'h10), .Saturate(1'b1), .Threshold(8'h40)) u_sat (
        .clk(clk), .rst(rst), .we(we), .wd(wd), .de(de), .d(d),
        .incr(incr), .incr_val(incr_val), .decr(decr), .decr_val(decr_val), .ovf_clr(ovf_clr),
`ifdef RDL_SUBREG_CNT_RCLR_EN
        .re(re),
`endif
        .q(q_a[1]), .qe(qe_a[1]), .qs(qs_a[1]), .overflow(ovf_a[1]), .underflow(unf_a[1]),
        .ovf_sticky(st_a[1]), .thresh(th_a[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string name);
        for (int i = 0; i < 2; i++) begin
            check({name, "_q"}, i, q_a[i], 8'h10);
            check({name, "_flags"}, i, {5'd0, ovf_a[i], unf_a[i], st_a[i]}, 8'h00);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i]  = 8'h10;
            m_st[i] = 1'b0;
        end
    endfunction

    // Apply one cycle of inputs and queue what each instance must show.
    task automatic drive(input logic we_i, input logic [7:0] wd_i, input logic de_i, input logic [7:0] d_i,
                         input logic incr_i, input logic [7:0] iv_i, input logic decr_i, input logic [7:0] dv_i,
                         input logic clr_i, input logic re_i);
        logic re_e;
        @(negedge clk);
`ifdef RDL_SUBREG_CNT_RCLR_EN
        re_e = re_i;
`else
        re_e = 1'b0;
`endif
        we = we_i; wd = wd_i; de = de_i; d = d_i;
        incr = incr_i; incr_val = iv_i; decr = decr_i; decr_val = dv_i;
        ovf_clr = clr_i; re = re_e;
        for (int i = 0; i < 2; i++) begin
            int         s;
            logic       o;
            logic       u;
            logic [7:0] nq;
            logic [7:0] pre;
            pre = m_q[i];
            o = 1'b0;
            u = 1'b0;
            if (we_i) begin
                nq = wd_i;
            end else if (de_i) begin
                nq = d_i;
            end else begin
                s = (re_e ? 0 : int'(m_q[i])) + (incr_i ? int'(iv_i) : 0) - (decr_i ? int'(dv_i) : 0);
                o = (s > 255);
                u = (s < 0);
                if (o) nq = m_sat[i] ? 8'hFF : 8'(s - 256);
                else if (u) nq = m_sat[i] ? 8'h00 : 8'(s + 256);
                else nq = 8'(s);
            end
            m_st[i] = o | (m_st[i] & ~clr_i);
            m_q[i]  = nq;
            exp_q.push_back({pre, we_i | de_i | re_e, nq, o, u, m_st[i], nq >= 8'h40});
        end
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] v);
        drive(1'b1, v, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
    endtask

    // Monitor: combinational outputs before the edge, registered outputs after it.
    initial begin
        logic [EW-1:0] e [2];
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() >= 2) begin
                e[0] = exp_q.pop_front();
                e[1] = exp_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    check("qs_pre", i, qs_a[i], e[i][20:13]);
                    check("qe", i, {7'd0, qe_a[i]}, {7'd0, e[i][12]});
                end
                @(posedge clk);
                #1;
                for (int i = 0; i < 2; i++) begin
                    check("q", i, q_a[i], e[i][11:4]);
                    check("qs", i, qs_a[i], e[i][11:4]);
                    check("overflow", i, {7'd0, ovf_a[i]}, {7'd0, e[i][3]});
                    check("underflow", i, {7'd0, unf_a[i]}, {7'd0, e[i][2]});
                    check("ovf_sticky", i, {7'd0, st_a[i]}, {7'd0, e[i][1]});
                    check("thresh", i, {7'd0, th_a[i]}, {7'd0, e[i][0]});
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_sat[0] = 1'b0;
        m_sat[1] = 1'b1;
        model_reset();
        rst = 1'b0;
        we = 0; wd = 0; de = 0; d = 0; incr = 0; incr_val = 0;
        decr = 0; decr_val = 0; ovf_clr = 0; re = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Wrap / saturate on overflow, then clear the sticky flag.
        load(8'hFE);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd3, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow held for two cycles, then count back up.
        load(8'h02);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd4, 1'b0, 8'h00, 1'b0, 1'b0);

        // Priority: we beats de beats counting; zero step is a no-op.
        load(8'h20);
        drive(1'b1, 8'h55, 1'b1, 8'hAA, 1'b1, 8'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 8'hAA, 1'b1, 8'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Net incr/decr crossing the threshold, then set-wins-over-clear.
        load(8'h3E);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd5, 1'b1, 8'd2, 1'b0, 1'b0);
        load(8'hFE);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd3, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();

`ifdef RDL_SUBREG_CNT_RCLR_EN
        load(8'h30);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
`endif

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] iv;
            logic [7:0] dv;
            iv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8));
            dv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 8));
            drive($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 15) == 0, 8'($urandom),
                  1'($urandom), iv, 1'($urandom), dv, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        idle();
        drain();

        // Reset asserted between edges while counting: takes effect without a clock.
        @(negedge clk);
        we = 0; de = 0; incr = 1; incr_val = 8'd7; decr = 0; ovf_clr = 0; re = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        incr = 0;
        @(posedge clk);
        #1;
        check_reset_state("reset_held");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'd1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
